siphash_msg_ctrl: RTL and testbench
===================================

# siphash_msg_ctrl

Message sequencer for the SipHash core. It accepts a key and a little-endian 64-bit word stream with a valid/ready handshake. It drives the core's initialize/compress/finalize commands, builds the final length-padded block, and returns the 64-bit digest with a done pulse. It sits between a bus wrapper or DMA stream and one `siphash_core` instance, and is the only master of that core's command inputs.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain.
- `start`  in  1  begin a new message; ignored while `busy`=1.
- `key`  in  128  k1:k0, with k0 in [63:0]; sampled when `start` is accepted.
- `s_data`  in  64  message word; byte 0 in [7:0].
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  final beat of the message.
- `s_bytes`  in  4  valid bytes on the last beat, 0..8. Values above 8 are treated as 8. Ignored on non-last beats, which always carry 8 bytes.
- `s_ready`  out  1  word accepted when `s_valid`&`s_ready`.
- `busy`  out  1  message in progress.
- `done`  out  1  one-cycle pulse; digest available.
- `digest`  out  64  result; held until the next accepted `start`.
- `core_initalize`, `core_compress`, `core_finalize`  out  1 each  one-cycle command pulses to the core.
- `core_long`  out  1  constant 0.
- `core_key`  out  128  registered key.
- `core_mi`  out  64  message block; valid during the `core_compress` cycle.
- `core_compression_rounds`, `core_final_rounds`  out  4  round counts.
- `core_ready`  in  1  core idle.
- `core_word`  in  64  core digest, bits [63:0].
- `core_word_valid`  in  1  core digest valid.

## Operation
- Byte counter `len` is 8 bits and wraps modulo 256. Only `len` mod 256 enters the padding.
- Pad block: `{len_total[7:0], 56-bit data}`, where data bytes at index `s_bytes` and above are zeroed.
- The state machine has nine states:
  - IDLE: `busy`=0. On `start`, register `key`, clear `len`, go to INIT.
  - INIT: pulse `core_initalize`, then go to ACCEPT.
  - ACCEPT: `s_ready`=`core_ready`. Behaviour on a handshake depends on the beat:
    - Non-last beat: compress `s_data`, `len`+=8, next=ACCEPT.
    - Last beat with `s_bytes`=8: compress `s_data`, `len`+=8, next=PAD.
    - Last beat with `s_bytes`<8: compress the pad block using `len`+`s_bytes`, next=FIN.
    - Every handshake goes to CWAIT.
  - CWAIT: wait at least one cycle, then wait until `core_ready`=1. Go to the stored next state.
  - PAD: compress `{len[7:0], 56'h0}`, go to CWAIT, next=FIN.
  - FIN: pulse `core_finalize`, go to FWAIT.
  - FWAIT: when `core_word_valid`=1, register `digest`=`core_word` and go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `s_ready` is 0 in every state except ACCEPT.
- At most one core command is asserted per cycle, and never while the core is busy.
- A `start` pulse while `busy`=1 has no effect. A `start` pulse in DONE is ignored.
- `reset` during a message: the block returns to IDLE, and `digest`, `len` and the key register are cleared. The core must be reset together with this block.

## Timing
- Reset values: `s_ready`=0, `busy`=0, `done`=0, `digest`=0, all `core_*` command pulses=0, `core_key`=0, `core_mi`=0.
- `start` accepted at cycle t:
  - `busy`=1 at t+1.
  - `core_initalize` at t+1.
  - `s_ready` can first be 1 at t+2.
- Per-word cost is c+3 cycles from handshake to the next `s_ready`, where c is the compression round count. This includes the CWAIT minimum cycle.
- Finalization with d final rounds: `done` follows the `core_finalize` cycle after d+3 cycles.
- `core_mi` is registered and is driven in the same cycle as `core_compress`.

## Configuration
- `SIPHASH_CTRL_ROUNDS_CFG_EN` defined:
  - Adds input ports `compression_rounds[3:0]` and `final_rounds[3:0]`, both sampled with `start`.
  - A sampled value of 0 is clamped to 1.
- `SIPHASH_CTRL_ROUNDS_CFG_EN` undefined: no round ports; the round counts are fixed at 2 and 4 (SipHash-2-4).

## Test plan
Common setup: key=`0x0f0e0d0c0b0a0908_0706050403020100`, SipHash-2-4, a real `siphash_core` attached.

- Empty message, single beat with `s_last`=1, `s_bytes`=0 -> `digest`=`0x726fdb47dd0e0e31`, `done` pulses once.
- 8 bytes 00..07, `s_data`=`0x0706050403020100`, `s_last`=1, `s_bytes`=8 -> a PAD block `0x0800000000000000` is compressed and `digest`=`0x93f5f5799a932462`.
- 15 bytes 00..0e, sent as 2 beats with the last beat `s_bytes`=7 -> `digest`=`0xa129ca6149be45e5`.
- `s_valid` toggling randomly over a 15-byte message, plus `start` pulsed while busy -> the same digest, no extra core commands, and `s_ready`=0 outside ACCEPT.
- 300-byte message -> the pad byte is `0x2c` (`len` wrap) and the result matches the software model.
- `reset` asserted during CWAIT -> next cycle `busy`=0, `digest`=0, `s_ready`=0. A following empty-message run returns `0x726fdb47dd0e0e31`.

Source files
------------

// File: rtl/siphash_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : siphash_msg_ctrl
// Purpose  : Turns a key plus a little-endian 64-bit word stream into
//            siphash_core init/compress/finalize commands, builds the
//            length-padded final block and returns the 64-bit digest.
// Options  : SIPHASH_CTRL_ROUNDS_CFG_EN adds run-time round count inputs.
// Revision : 1.0
// ============================================================================
module siphash_msg_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
`ifdef SIPHASH_CTRL_ROUNDS_CFG_EN
  input  logic [3:0]   compression_rounds,
  input  logic [3:0]   final_rounds,
`endif
  input  logic [63:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic [3:0]   s_bytes,
  output logic         s_ready,
  output logic         busy,
  output logic         done,
  output logic [63:0]  digest,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [127:0] core_key,
  output logic [63:0]  core_mi,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  input  logic         core_ready,
  input  logic [63:0]  core_word,
  input  logic         core_word_valid
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_ACCEPT = 4'd2,
    ST_CWAIT1 = 4'd3,
    ST_CWAIT  = 4'd4,
    ST_PAD    = 4'd5,
    ST_FIN    = 4'd6,
    ST_FWAIT  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  state_t        state_q;
  state_t        after_q;
  logic [7:0]    len_q;
  logic [127:0]  key_q;
  logic [63:0]   digest_q;
  logic [63:0]   mi_q;
  logic          busy_q;
  logic          done_q;
  logic          init_q;
  logic          comp_q;
  logic          fin_q;

  logic [3:0]    bytes_d;
  logic [7:0]    len_sum_d;
  logic [63:0]   pad_mi_d;

  // Final block: running length mod 256 in the top byte, unused data bytes zeroed.
  always_comb begin
    bytes_d   = (s_bytes > 4'd8) ? 4'd8 : s_bytes;
    len_sum_d = len_q + {4'd0, bytes_d};
    pad_mi_d  = {len_sum_d, 56'd0};
    for (int i = 0; i < 7; i++) begin
      if (4'(i) < bytes_d) pad_mi_d[8*i +: 8] = s_data[8*i +: 8];
    end
  end

`ifdef SIPHASH_CTRL_ROUNDS_CFG_EN
  logic [3:0] crounds_q;
  logic [3:0] frounds_q;
  assign core_compression_rounds = crounds_q;
  assign core_final_rounds       = frounds_q;
`else
  assign core_compression_rounds = 4'd2;
  assign core_final_rounds       = 4'd4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      after_q  <= ST_IDLE;
      len_q    <= 8'd0;
      key_q    <= 128'd0;
      digest_q <= 64'd0;
      mi_q     <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      init_q   <= 1'b0;
      comp_q   <= 1'b0;
      fin_q    <= 1'b0;
`ifdef SIPHASH_CTRL_ROUNDS_CFG_EN
      crounds_q <= 4'd2;
      frounds_q <= 4'd4;
`endif
    end else begin
      init_q <= 1'b0;
      comp_q <= 1'b0;
      fin_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q   <= key;
            len_q   <= 8'd0;
            busy_q  <= 1'b1;
            init_q  <= 1'b1;
            state_q <= ST_INIT;
`ifdef SIPHASH_CTRL_ROUNDS_CFG_EN
            crounds_q <= (compression_rounds == 4'd0) ? 4'd1 : compression_rounds;
            frounds_q <= (final_rounds == 4'd0) ? 4'd1 : final_rounds;
`endif
          end
        end
        ST_INIT: state_q <= ST_ACCEPT;
        ST_ACCEPT: begin
          if (s_valid && core_ready) begin
            comp_q  <= 1'b1;
            state_q <= ST_CWAIT1;
            if (!s_last || bytes_d == 4'd8) begin
              mi_q    <= s_data;
              len_q   <= len_q + 8'd8;
              after_q <= s_last ? ST_PAD : ST_ACCEPT;
            end else begin
              mi_q    <= pad_mi_d;
              len_q   <= len_sum_d;
              after_q <= ST_FIN;
            end
          end
        end
        // The core only drops core_ready a cycle after the command.
        ST_CWAIT1: state_q <= ST_CWAIT;
        ST_CWAIT: begin
          if (core_ready) begin
            state_q <= after_q;
            if (after_q == ST_FIN) fin_q <= 1'b1;
          end
        end
        ST_PAD: begin
          mi_q    <= {len_q, 56'd0};
          comp_q  <= 1'b1;
          after_q <= ST_FIN;
          state_q <= ST_CWAIT1;
        end
        ST_FIN: state_q <= ST_FWAIT;
        ST_FWAIT: begin
          if (core_word_valid) begin
            digest_q <= core_word;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready        = (state_q == ST_ACCEPT) & core_ready;
  assign busy           = busy_q;
  assign done           = done_q;
  assign digest         = digest_q;
  assign core_initalize = init_q;
  assign core_compress  = comp_q;
  assign core_finalize  = fin_q;
  assign core_long      = 1'b0;
  assign core_key       = key_q;
  assign core_mi        = mi_q;

endmodule
`default_nettype wire

// File: tb/tb_siphash_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_siphash_msg_ctrl
// Purpose  : Self-checking bench: behavioural SipHash-2-4 core attached to the
//            sequencer, software SipHash reference, randomized stream stimulus.
// Revision : 1.0
// ============================================================================
module tb_siphash_msg_ctrl;

  localparam int           C_ROUNDS = 2;
  localparam int           D_ROUNDS = 4;
  localparam logic [127:0] KEY0     = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, s_valid, s_last, s_ready, busy, done;
  logic [127:0] key, core_key;
  logic [63:0]  s_data, digest, core_mi, core_word;
  logic [3:0]   s_bytes, core_compression_rounds, core_final_rounds;
  logic         core_initalize, core_compress, core_finalize, core_long;
  logic         core_ready, core_word_valid;

  siphash_msg_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
`ifdef SIPHASH_CTRL_ROUNDS_CFG_EN
    .compression_rounds(4'd2), .final_rounds(4'd4),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes),
    .s_ready(s_ready), .busy(busy), .done(done), .digest(digest),
    .core_initalize(core_initalize), .core_compress(core_compress),
    .core_finalize(core_finalize), .core_long(core_long), .core_key(core_key),
    .core_mi(core_mi), .core_compression_rounds(core_compression_rounds),
    .core_final_rounds(core_final_rounds), .core_ready(core_ready),
    .core_word(core_word), .core_word_valid(core_word_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SipHash arithmetic (state packed as {v3,v2,v1,v0}) ----
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [255:0] sipround(input logic [255:0] s);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = s;
    v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
    v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
    v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
    v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] sip_init(input logic [127:0] k);
    return {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
            k[127:64] ^ 64'h646f72616e646f6d, k[63:0] ^ 64'h736f6d6570736575};
  endfunction

  function automatic logic [255:0] sip_comp(input logic [255:0] s, input logic [63:0] m, input int n);
    logic [255:0] t;
    t = s;
    t[255:192] = t[255:192] ^ m;
    for (int r = 0; r < n; r++) t = sipround(t);
    t[63:0] = t[63:0] ^ m;
    return t;
  endfunction

  function automatic logic [255:0] sip_fin(input logic [255:0] s, input int n);
    logic [255:0] t;
    t = s;
    t[191:128] = t[191:128] ^ 64'hff;
    for (int r = 0; r < n; r++) t = sipround(t);
    return t;
  endfunction

  function automatic logic [63:0] sip_fold(input logic [255:0] s);
    return s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
  endfunction

  // ---------------- attached core: compress busy c cycles, finalize d+1 ----
  logic [255:0] cv;
  int           ccnt;
  logic         cfin;
  assign core_ready      = (ccnt == 0);
  assign core_word_valid = cfin && (ccnt == 0);
  assign core_word       = sip_fold(cv);

  always @(posedge clk) begin
    if (reset) begin
      cv <= '0; ccnt <= 0; cfin <= 1'b0;
    end else if (core_initalize) begin
      cv <= sip_init(core_key); cfin <= 1'b0;
    end else if (core_compress) begin
      cv <= sip_comp(cv, core_mi, int'(core_compression_rounds));
      ccnt <= int'(core_compression_rounds); cfin <= 1'b0;
    end else if (core_finalize) begin
      cv <= sip_fin(cv, int'(core_final_rounds));
      ccnt <= int'(core_final_rounds) + 1; cfin <= 1'b1;
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
    end
  end

  // ---------------- software reference over the byte message ----------------
  byte unsigned msg [0:511];
  logic [63:0]  exp_blocks[$];
  logic [63:0]  exp_digest;
  logic [127:0] cur_key;

  task automatic sw_model(input logic [127:0] k, input int len, input bit rec, output logic [63:0] dg);
    logic [255:0] v;
    logic [63:0]  m;
    int           nfull;
    v = sip_init(k);
    nfull = len / 8;
    for (int w = 0; w < nfull; w++) begin
      for (int b = 0; b < 8; b++) m[8*b +: 8] = msg[8*w + b];
      if (rec) exp_blocks.push_back(m);
      v = sip_comp(v, m, C_ROUNDS);
    end
    m = '0;
    m[63:56] = 8'(len);
    for (int b = 0; b < len % 8; b++) m[8*b +: 8] = msg[8*nfull + b];
    if (rec) exp_blocks.push_back(m);
    v = sip_comp(v, m, C_ROUNDS);
    dg = sip_fold(sip_fin(v, D_ROUNDS));
  endtask

  // ---------------- per-cycle compare process ----------------
  int          cyc = 0, hs_cyc = 0, fin_cyc = 0, acc_stage = 0, ncmd;
  int          done_cnt = 0, n_init = 0, n_comp = 0, n_fin = 0;
  bit          hs_pend = 1'b0, post_last = 1'b0;
  logic [63:0] got_digest = '0, last_mi = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_blocks.delete();
        hs_pend = 1'b0; post_last = 1'b0; acc_stage = 0;
      end else begin
        ncmd = int'(core_initalize) + int'(core_compress) + int'(core_finalize);
        chk("cmd_onehot", 64'(ncmd <= 1), 64'd1);
        if (ncmd != 0) chk("cmd_core_idle", 64'(core_ready), 64'd1);
        chk("core_long", 64'(core_long), 64'd0);
        chk("rounds", 64'({core_compression_rounds, core_final_rounds}), 64'h24);
        if (busy) chk("core_key", core_key[63:0] ^ core_key[127:64], cur_key[63:0] ^ cur_key[127:64]);
        if (!busy || post_last) chk("s_ready_outside_accept", 64'(s_ready), 64'd0);
        if (!busy) chk("done_idle", 64'(done), 64'd0);
        if (acc_stage == 2) begin
          chk("s_ready_t2", 64'(s_ready), 64'd1);
          acc_stage = 0;
        end
        if (acc_stage == 1) begin
          chk("busy_t1", 64'(busy), 64'd1);
          chk("init_t1", 64'(core_initalize), 64'd1);
          acc_stage = 2;
        end
        if (start && !busy) acc_stage = 1;
        if (core_initalize) n_init++;
        if (core_finalize) begin n_fin++; fin_cyc = cyc; end
        if (core_compress) begin
          n_comp++;
          last_mi = core_mi;
          if (exp_blocks.size() == 0) chk("extra_compress", 64'(exp_blocks.size()), 64'd1);
          else chk("core_mi", core_mi, exp_blocks.pop_front());
        end
        if (hs_pend && s_ready) begin
          chk("word_cost", 64'(cyc - hs_cyc), 64'(C_ROUNDS + 3));
          hs_pend = 1'b0;
        end
        if (s_valid && s_ready) begin
          if (!s_last) begin hs_pend = 1'b1; hs_cyc = cyc; end
          else post_last = 1'b1;
        end
        if (done) begin
          done_cnt++;
          got_digest = digest;
          chk("digest", digest, exp_digest);
          chk("done_latency", 64'(cyc - fin_cyc), 64'(D_ROUNDS + 3));
          post_last = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_msg(input logic [127:0] k, input int len, input int vprob, input bit poke);
    int nb, beat, guard, nby, db, ib, icm, ifn;
    logic [63:0] d;
    nb = (len == 0) ? 1 : (len + 7) / 8;
    sw_model(k, len, 1'b1, exp_digest);
    cur_key = k;
    db = done_cnt; ib = n_init; icm = n_comp; ifn = n_fin;
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beat = 0; guard = 0;
    while (beat < nb && guard < 4000) begin
      s_last = (beat == nb - 1);
      nby = s_last ? len - 8*beat : 8;
      d = {$urandom, $urandom};
      for (int b = 0; b < nby; b++) d[8*b +: 8] = msg[8*beat + b];
      s_data = d;
      if (!s_last) s_bytes = 4'($urandom);
      else if (nby == 8 && $urandom_range(0, 1) == 1) s_bytes = 4'($urandom_range(9, 15));
      else s_bytes = 4'(nby);
      s_valid = ($urandom_range(0, 99) < vprob);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (s_valid && s_ready) beat++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    chk("beats_accepted", 64'(beat), 64'(nb));
    guard = 0;
    while (done_cnt == db && guard < 300) begin @(posedge clk); #1; guard++; end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - db), 64'd1);
    chk("init_cmds", 64'(n_init - ib), 64'd1);
    chk("compress_cmds", 64'(n_comp - icm), 64'(len / 8 + 1));
    chk("final_cmds", 64'(n_fin - ifn), 64'd1);
  endtask

  initial begin
    logic [63:0]  dg;
    logic [127:0] rk;
    int           g, rlen;
    reset = 1'b1; start = 1'b0; key = '0; s_data = '0;
    s_valid = 1'b0; s_last = 1'b0; s_bytes = '0; cur_key = '0; exp_digest = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_digest", digest, 64'd0);
    chk("rst_cmds", 64'({core_initalize, core_compress, core_finalize}), 64'd0);
    chk("rst_core_key", core_key[63:0] | core_key[127:64], 64'd0);
    chk("rst_core_mi", core_mi, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) msg[i] = 8'(i);
    sw_model(KEY0, 0, 1'b0, dg);  chk("model_empty", dg, 64'h726fdb47dd0e0e31);
    sw_model(KEY0, 8, 1'b0, dg);  chk("model_8b", dg, 64'h93f5f5799a932462);
    sw_model(KEY0, 15, 1'b0, dg); chk("model_15b", dg, 64'ha129ca6149be45e5);

    @(posedge clk); #1;
    send_msg(KEY0, 0, 100, 1'b0);
    chk("dut_empty", got_digest, 64'h726fdb47dd0e0e31);
    send_msg(KEY0, 8, 100, 1'b0);
    chk("dut_8b", got_digest, 64'h93f5f5799a932462);
    chk("pad_block_8b", last_mi, 64'h0800000000000000);
    send_msg(KEY0, 15, 100, 1'b0);
    chk("dut_15b", got_digest, 64'ha129ca6149be45e5);
    send_msg(KEY0, 15, 40, 1'b1);
    chk("dut_15b_toggle", got_digest, 64'ha129ca6149be45e5);

    for (int i = 0; i < 300; i++) msg[i] = 8'($urandom);
    send_msg(KEY0, 300, 70, 1'b1);
    chk("pad_byte_300", 64'(last_mi[63:56]), 64'h2c);

    for (int n = 0; n < 14; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rlen = (n < 4) ? 8 * n : int'($urandom_range(0, 40));
      for (int i = 0; i < rlen; i++) msg[i] = 8'($urandom);
      send_msg(rk, rlen, int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)));
    end

    // reset while the controller waits on a compress
    for (int i = 0; i < 16; i++) msg[i] = 8'(i);
    sw_model(KEY0, 16, 1'b1, exp_digest);
    cur_key = KEY0; key = KEY0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_bytes = 4'd8; s_data = 64'h0706050403020100;
    g = 0;
    while (!s_ready && g < 20) begin @(posedge clk); #1; g++; end
    chk("rst_test_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_test_cwait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_digest", digest, 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_core_key", core_key[63:0] | core_key[127:64], 64'd0);
    @(posedge clk); #1;
    send_msg(KEY0, 0, 100, 1'b0);
    chk("dut_empty_after_rst", got_digest, 64'h726fdb47dd0e0e31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
